// File: rtl/serial_comparator.sv
// Multi-cycle MSB-first magnitude comparator: W bits of each N-bit operand per cycle.
// Optional min/max outputs are enabled by defining SERIAL_COMPARATOR_MINMAX_EN.
module serial_comparator #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_left,
  input  logic [N-1:0] i_right,
  input  logic         i_signed,
  output logic         o_valid,
  output logic         o_greater,
  output logic         o_equal,
  output logic         o_less,
  output logic         o_greater_equal,
  output logic         o_not_equal,
  output logic         o_less_equal
`ifdef SERIAL_COMPARATOR_MINMAX_EN
  ,
  output logic [N-1:0] o_max,
  output logic [N-1:0] o_min
`endif
);

  localparam int unsigned STEPS = N / W;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    left_q, left_d, right_q, right_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_gt_q, run_gt_d, run_eq_q, run_eq_d, run_lt_q, run_lt_d;
  logic            ready_d, valid_d;
  logic            gt_d, eq_d, lt_d, ge_d, ne_d, le_d;
  logic            step_gt, step_eq, step_lt;
  logic [W-1:0]    chunk_l, chunk_r;

`ifdef SERIAL_COMPARATOR_MINMAX_EN
  logic [N-1:0]    orig_l_q, orig_l_d, orig_r_q, orig_r_d, max_d, min_d;
`endif

  // Operands shift left each step so the chunk under compare is always at the top.
  assign chunk_l = left_q[N-1 -: W];
  assign chunk_r = right_q[N-1 -: W];

  assign step_gt = run_gt_q | (run_eq_q & (chunk_l > chunk_r));
  assign step_lt = run_lt_q | (run_eq_q & (chunk_l < chunk_r));
  assign step_eq = run_eq_q & (chunk_l == chunk_r);

  // Next-state and datapath next values.
  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    cnt_d    = cnt_q;
    run_gt_d = run_gt_q;
    run_eq_d = run_eq_q;
    run_lt_d = run_lt_q;
    valid_d  = o_valid;
    gt_d     = o_greater;
    eq_d     = o_equal;
    lt_d     = o_less;
    ge_d     = o_greater_equal;
    ne_d     = o_not_equal;
    le_d     = o_less_equal;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
    orig_l_d = orig_l_q;
    orig_r_d = orig_r_q;
    max_d    = o_max;
    min_d    = o_min;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          left_d   = i_left  ^ {i_signed, {(N-1){1'b0}}};
          right_d  = i_right ^ {i_signed, {(N-1){1'b0}}};
          cnt_d    = '0;
          run_gt_d = 1'b0;
          run_eq_d = 1'b1;
          run_lt_d = 1'b0;
          valid_d  = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          ge_d     = 1'b0;
          ne_d     = 1'b0;
          le_d     = 1'b0;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
          orig_l_d = i_left;
          orig_r_d = i_right;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        left_d   = left_q << W;
        right_d  = right_q << W;
        run_gt_d = step_gt;
        run_eq_d = step_eq;
        run_lt_d = step_lt;
        if (cnt_q == CW'(STEPS - 1)) begin
          valid_d = 1'b1;
          gt_d    = step_gt;
          eq_d    = step_eq;
          lt_d    = step_lt;
          ge_d    = step_gt | step_eq;
          ne_d    = step_gt | step_lt;
          le_d    = step_lt | step_eq;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
          max_d   = step_lt ? orig_r_q : orig_l_q;
          min_d   = step_gt ? orig_r_q : orig_l_q;
`endif
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset takes priority over an accept.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= S_IDLE;
      left_q          <= '0;
      right_q         <= '0;
      cnt_q           <= '0;
      run_gt_q        <= 1'b0;
      run_eq_q        <= 1'b0;
      run_lt_q        <= 1'b0;
      o_ready         <= 1'b1;
      o_valid         <= 1'b0;
      o_greater       <= 1'b0;
      o_equal         <= 1'b0;
      o_less          <= 1'b0;
      o_greater_equal <= 1'b0;
      o_not_equal     <= 1'b0;
      o_less_equal    <= 1'b0;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
      orig_l_q        <= '0;
      orig_r_q        <= '0;
      o_max           <= '0;
      o_min           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      left_q          <= left_d;
      right_q         <= right_d;
      cnt_q           <= cnt_d;
      run_gt_q        <= run_gt_d;
      run_eq_q        <= run_eq_d;
      run_lt_q        <= run_lt_d;
      o_ready         <= ready_d;
      o_valid         <= valid_d;
      o_greater       <= gt_d;
      o_equal         <= eq_d;
      o_less          <= lt_d;
      o_greater_equal <= ge_d;
      o_not_equal     <= ne_d;
      o_less_equal    <= le_d;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
      orig_l_q        <= orig_l_d;
      orig_r_q        <= orig_r_d;
      o_max           <= max_d;
      o_min           <= min_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed corner cases plus random transactions checked
// against an integer-arithmetic reference; a second W=N instance checks single-cycle latency.
module tb_serial_comparator;

  localparam int unsigned N = 8;
  localparam int unsigned W = 2;
  localparam int STEPS = N / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, valid1;
  logic [N-1:0] left_v, right_v;
  logic         signed_v;

  logic ready, ovalid, gt, eq, lt, ge, ne, le;
  logic ready1, ovalid1, gt1, eq1, lt1, ge1, ne1, le1;
`ifdef SERIAL_COMPARATOR_MINMAX_EN
  logic [N-1:0] omax, omin, omax1, omin1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  serial_comparator #(.N(N), .W(W)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
    .i_left(left_v), .i_right(right_v), .i_signed(signed_v),
    .o_valid(ovalid), .o_greater(gt), .o_equal(eq), .o_less(lt),
    .o_greater_equal(ge), .o_not_equal(ne), .o_less_equal(le)
`ifdef SERIAL_COMPARATOR_MINMAX_EN
    , .o_max(omax), .o_min(omin)
`endif
  );

  serial_comparator #(.N(N), .W(N)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid1), .o_ready(ready1),
    .i_left(left_v), .i_right(right_v), .i_signed(signed_v),
    .o_valid(ovalid1), .o_greater(gt1), .o_equal(eq1), .o_less(lt1),
    .o_greater_equal(ge1), .o_not_equal(ne1), .o_less_equal(le1)
`ifdef SERIAL_COMPARATOR_MINMAX_EN
    , .o_max(omax1), .o_min(omin1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int val(input logic [N-1:0] v, input logic s);
    return s ? int'($signed(v)) : int'({1'b0, v});
  endfunction

  // Reference: plain integer comparison of the interpreted operand values.
  task automatic check_result(input string tag, input logic [N-1:0] l, input logic [N-1:0] r,
                              input logic s);
    int a, b;
    a = val(l, s);
    b = val(r, s);
    chk({tag, ".valid"}, 32'(ovalid), 32'd1);
    chk({tag, ".ready"}, 32'(ready),  32'd1);
    chk({tag, ".flags"}, {26'd0, gt, eq, lt, ge, ne, le},
        {26'd0, a > b, a == b, a < b, a >= b, a != b, a <= b});
`ifdef SERIAL_COMPARATOR_MINMAX_EN
    chk({tag, ".max"}, 32'(omax), 32'((a < b) ? r : l));
    chk({tag, ".min"}, 32'(omin), 32'((a > b) ? r : l));
`endif
  endtask

  // Accept one transaction on the W=2 instance and wait (bounded) for its result.
  task automatic run(input string tag, input logic [N-1:0] l, input logic [N-1:0] r,
                     input logic s);
    int t;
    t = 0;
    while (!ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    left_v = l; right_v = r; signed_v = s; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk({tag, ".busy"}, {30'd0, ready, ovalid}, 32'd0);
    lat = 0;
    while (!ovalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(STEPS));
    check_result(tag, l, r, s);
  endtask

  initial begin
    logic [N-1:0] l, r;
    logic s;
    rst = 1'b1; valid = 1'b0; valid1 = 1'b0;
    left_v = '0; right_v = '0; signed_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", {24'd0, ready, ovalid, gt, eq, lt, ge, ne, le}, 32'h80);
    chk("reset.state1", {24'd0, ready1, ovalid1, gt1, eq1, lt1, ge1, ne1, le1}, 32'h80);
`ifdef SERIAL_COMPARATOR_MINMAX_EN
    chk("reset.minmax", {16'd0, omax, omin}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run("t1", 8'hA5, 8'h5A, 1'b0);
    run("t2s", 8'h80, 8'h7F, 1'b1);
    run("t2u", 8'h80, 8'h7F, 1'b0);
    run("t3eq", 8'h3C, 8'h3C, 1'b0);
    run("t3lsb", 8'h3C, 8'h3D, 1'b0);
    run("t6s", 8'hFF, 8'h01, 1'b1);
    run("t6u", 8'hFF, 8'h01, 1'b0);

    // Input held valid with new operands during RUN; first result must be reported.
    left_v = 8'h10; right_v = 8'h20; signed_v = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    left_v = 8'hF0; right_v = 8'h01; signed_v = 1'b1;
    repeat (STEPS - 1) begin
      @(posedge clk); #1;
    end
    chk("t4.notyet", 32'(ovalid), 32'd0);
    @(posedge clk); #1;
    check_result("t4.first", 8'h10, 8'h20, 1'b0);
    // Back-to-back: still-valid input is accepted on the very next edge.
    @(posedge clk); #1;
    valid = 1'b0;
    chk("t4.drop", {30'd0, ovalid, ready}, 32'd0);
    repeat (STEPS) begin
      @(posedge clk); #1;
    end
    check_result("t4.second", 8'hF0, 8'h01, 1'b1);

    // Reset in the second RUN cycle aborts the transaction.
    left_v = 8'hC3; right_v = 8'h11; signed_v = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5.abort", {24'd0, ready, ovalid, gt, eq, lt, ge, ne, le}, 32'h80);
    repeat (STEPS) begin
      @(posedge clk); #1;
    end
    chk("t5.stays_idle", {30'd0, ready, ovalid}, 32'h2);

    // W = N instance: result one edge after accept.
    left_v = 8'h05; right_v = 8'hFB; signed_v = 1'b1; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    chk("t5w8.run", {30'd0, ready1, ovalid1}, 32'd0);
    @(posedge clk); #1;
    chk("t5w8.result", {24'd0, ready1, ovalid1, gt1, eq1, lt1, ge1, ne1, le1},
        {24'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

    // Random transactions, with biased equality/near-equality cases.
    for (int i = 0; i < 40; i++) begin
      l = N'($urandom);
      case ($urandom_range(0, 3))
        0: r = l;
        1: r = l ^ N'(1 << $urandom_range(0, N - 1));
        default: r = N'($urandom);
      endcase
      s = 1'($urandom);
      run($sformatf("rand%0d", i), l, r, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
